// File: rtl/prog_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit instruction words,
// writes them from BASE_ADDR upward and releases the CPU once the XOR checksum verifies.
module prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_written
);

   typedef enum logic [2:0] {
      S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE, S_ERR
   } state_e;

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);

   state_e          state_q, state_d;
   logic [ADDR_W:0] len_q, len_d;
   logic [ADDR_W:0] words_q, words_d;
   logic [31:0]     word_q, word_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [7:0]      csum_q, csum_d;
   logic            hold_q, hold_d;
   logic            pulse_q, pulse_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      len_d      = len_q;
      words_d    = words_q;
      word_d     = word_q;
      byte_cnt_d = byte_cnt_q;
      csum_d     = csum_q;
      hold_d     = hold_q;
      pulse_d    = 1'b0;
      done_d     = done_q;
      err_d      = err_q;
      in_ready   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               hold_d  = 1'b1;
               done_d  = 1'b0;
               words_d = '0;
               if (len > DEPTH_L) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  err_d      = 1'b0;
                  len_d      = len;
                  csum_d     = '0;
                  byte_cnt_d = '0;
                  state_d    = (len == '0) ? S_CHECK : S_RECV;
               end
            end
         end
         S_RECV: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Shifting in from the bottom leaves the first byte of the word at the MSB.
               word_d     = {word_q[23:0], in_data};
               csum_d     = csum_q ^ in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = BASE_L + words_q[ADDR_W-1:0];
            mem_wdata = word_q;
            words_d   = words_q + ONE_L;
            state_d   = (words_d == len_q) ? S_CHECK : S_RECV;
         end
         S_CHECK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data == csum_q) begin
                  state_d = S_DONE;
                  hold_d  = 1'b0;
                  done_d  = 1'b1;
                  pulse_d = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         words_q    <= '0;
         word_q     <= '0;
         byte_cnt_q <= '0;
         csum_q     <= '0;
         hold_q     <= 1'b1;
         pulse_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         words_q    <= words_d;
         word_q     <= word_d;
         byte_cnt_q <= byte_cnt_d;
         csum_q     <= csum_d;
         hold_q     <= hold_d;
         pulse_q    <= pulse_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign busy          = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
   assign cpu_hold      = hold_q;
   assign cpu_start     = pulse_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a byte-count based reference model checked every
// cycle, plus literal expectations for the hand-computed loads.
module tb_prog_loader;

   localparam int ADDR_W    = 8;
   localparam int DEPTH     = 200;
   localparam int BASE_ADDR = 40;

   logic              clk1 = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   len = '0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready, mem_we, cpu_hold, cpu_start, busy, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   words_written;

   prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .clk1(clk1), .rst(rst), .start(start), .len(len), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy),
      .done(done), .err(err), .words_written(words_written)
   );

   always #5 clk1 = ~clk1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: tracks the load by how many stream bytes it has consumed.
   bit          m_ok = 0, m_active = 0, m_wr = 0, m_pulse = 0, m_hold = 1, m_done = 0, m_err = 0;
   int          m_len = 0, m_k = 0, m_words = 0;
   logic [7:0]  m_csum = '0;
   logic [31:0] m_word = '0;
   logic [ADDR_W-1:0] log_addr[$];
   logic [31:0]       log_data[$];
   int          start_cnt = 0;

   always @(negedge clk1) begin
      if (m_ok) begin
         check("in_ready", in_ready, m_active && !m_wr);
         check("mem_we", mem_we, m_wr);
         if (m_wr) begin
            check("mem_addr", mem_addr, BASE_ADDR + m_words);
            check("mem_wdata", mem_wdata, m_word);
         end
         check("cpu_hold", cpu_hold, m_hold);
         check("cpu_start", cpu_start, m_pulse);
         check("busy", busy, m_active);
         check("done", done, m_done);
         check("err", err, m_err);
         check("words_written", words_written, m_words);
      end
      if (mem_we === 1'b1) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
      end
      if (cpu_start === 1'b1) start_cnt++;

      if (rst) begin
         m_ok = 1; m_active = 0; m_wr = 0; m_pulse = 0; m_hold = 1; m_done = 0; m_err = 0;
         m_words = 0; m_k = 0; m_csum = '0;
      end else begin
         m_pulse = 0;
         if (m_wr) begin
            m_wr = 0;
            m_words++;
         end else if (m_active) begin
            if (in_valid) begin
               if (m_k < 4 * m_len) begin
                  m_word[31 - 8*(m_k % 4) -: 8] = in_data;
                  m_csum = m_csum ^ in_data;
                  if (m_k % 4 == 3) m_wr = 1;
                  m_k++;
               end else begin
                  m_active = 0;
                  if (in_data == m_csum) begin
                     m_done = 1; m_hold = 0; m_pulse = 1;
                  end else begin
                     m_err = 1;
                  end
               end
            end
         end else if (start) begin
            m_hold = 1; m_done = 0; m_err = 0; m_words = 0;
            if (int'(len) > DEPTH) m_err = 1;
            else begin
               m_active = 1; m_len = int'(len); m_k = 0; m_csum = '0;
            end
         end
      end
   end

   logic [31:0] prog[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W:0] l);
      start = 1'b1;
      len   = l;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap, input bit pulse);
      bit acc;
      int gap;
      acc = 0;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      in_valid = 1'b0;
      if (gap > 0) tick(gap);
      in_valid = 1'b1;
      in_data  = b;
      if (pulse) begin
         start = 1'b1;
         len   = (ADDR_W+1)'(3);
      end
      for (int c = 0; c < 100 && !acc; c++) begin
         @(negedge clk1);
         acc = (in_ready === 1'b1);
         tick(1);
         start = 1'b0;
      end
      in_valid = 1'b0;
      check("byte_accepted", acc, 1'b1);
   endtask

   task automatic send_words(input int max_gap, input int pulse_word, input int byte_limit,
                             output logic [7:0] cs);
      logic [7:0] b;
      int n;
      n  = 0;
      cs = '0;
      do_start((ADDR_W+1)'(prog.size()));
      foreach (prog[i]) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_limit < 0 || n < byte_limit) begin
               b  = 8'(prog[i] >> (24 - 8*k));
               cs = cs ^ b;
               send_byte(b, max_gap, (i == pulse_word) && (k == 0));
               n++;
            end
         end
      end
   endtask

   task automatic rand_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
   endtask

   task automatic check_log(input string tag, input int w0);
      check({tag, "_writes"}, log_addr.size() - w0, prog.size());
      foreach (prog[i]) begin
         if (w0 + i < log_addr.size()) begin
            check($sformatf("%s_addr%0d", tag, i), log_addr[w0+i], BASE_ADDR + i);
            check($sformatf("%s_data%0d", tag, i), log_data[w0+i], prog[i]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b0);
      check({tag, "_mem_we"}, mem_we, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_cpu_hold"}, cpu_hold, 1'b1);
      check({tag, "_cpu_start"}, cpu_start, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_words"}, words_written, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, s0;
      logic [7:0] cs;

      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      check_reset_outputs("reset");

      // Two-word load with the hand-computed checksum DD.
      prog = '{32'h28090000, 32'hFC000000};
      w0 = log_addr.size(); s0 = start_cnt;
      send_words(0, -1, -1, cs);
      send_byte(8'hDD, 0, 0);
      tick(2);
      check("t1_writes", log_addr.size() - w0, 2);
      if (log_addr.size() >= w0 + 2) begin
         check("t1_addr0", log_addr[w0], BASE_ADDR);
         check("t1_data0", log_data[w0], 32'h28090000);
         check("t1_addr1", log_addr[w0+1], BASE_ADDR + 1);
         check("t1_data1", log_data[w0+1], 32'hFC000000);
      end
      check("t1_start_pulses", start_cnt - s0, 1);
      check("t1_hold", cpu_hold, 1'b0);
      check("t1_done", done, 1'b1);
      check("t1_words", words_written, 2);

      // Same stream, wrong checksum byte.
      w0 = log_addr.size(); s0 = start_cnt;
      send_words(0, -1, -1, cs);
      send_byte(8'h00, 0, 0);
      tick(2);
      check("t2_writes", log_addr.size() - w0, 2);
      check("t2_err", err, 1'b1);
      check("t2_done", done, 1'b0);
      check("t2_hold", cpu_hold, 1'b1);
      check("t2_start_pulses", start_cnt - s0, 0);

      // len=0: only the checksum byte, which must be 00.
      prog.delete();
      w0 = log_addr.size(); s0 = start_cnt;
      send_words(0, -1, -1, cs);
      send_byte(8'h00, 0, 0);
      tick(2);
      check("t3_writes", log_addr.size() - w0, 0);
      check("t3_done", done, 1'b1);
      check("t3_start_pulses", start_cnt - s0, 1);
      s0 = start_cnt;
      send_words(0, -1, -1, cs);
      send_byte(8'h5A, 0, 0);
      tick(2);
      check("t3_bad_err", err, 1'b1);
      check("t3_bad_hold", cpu_hold, 1'b1);
      check("t3_bad_start_pulses", start_cnt - s0, 0);

      // Oversized length is refused immediately and consumes nothing.
      w0 = log_addr.size();
      do_start((ADDR_W+1)'(DEPTH + 1));
      check("t4_err", err, 1'b1);
      check("t4_in_ready", in_ready, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick(6);
      in_valid = 1'b0;
      check("t4_writes", log_addr.size() - w0, 0);
      check("t4_busy", busy, 1'b0);

      // 14 random words with random stalls and an ignored start pulse mid-load.
      rand_prog(14);
      w0 = log_addr.size(); s0 = start_cnt;
      send_words(3, 5, -1, cs);
      send_byte(cs, 3, 0);
      tick(2);
      check_log("t5", w0);
      check("t5_done", done, 1'b1);
      check("t5_start_pulses", start_cnt - s0, 1);

      // Full-depth load reaches the top address.
      rand_prog(DEPTH);
      w0 = log_addr.size();
      send_words(0, -1, -1, cs);
      send_byte(cs, 0, 0);
      tick(2);
      check_log("tdepth", w0);
      check("tdepth_done", done, 1'b1);
      check("tdepth_words", words_written, DEPTH);

      // Reset after word 3 of 14, then a fresh load.
      rand_prog(14);
      w0 = log_addr.size();
      send_words(2, -1, 12, cs);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_reset_outputs("t6_rst");
      in_valid = 1'b1;
      in_data  = 8'h11;
      tick(10);
      in_valid = 1'b0;
      check("t6_partial_writes", log_addr.size() - w0, 3);
      rand_prog(14);
      w0 = log_addr.size(); s0 = start_cnt;
      send_words(2, -1, -1, cs);
      send_byte(cs, 2, 0);
      tick(2);
      check_log("t6_fresh", w0);
      check("t6_done", done, 1'b1);
      check("t6_start_pulses", start_cnt - s0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
